// File: rtl/branch_predict.sv
// Conditional-branch predictor: 2-bit counter PHT + global history, F->D carry and Decode resolve.
// Build option: define BPU_GSHARE_EN for gshare indexing (PC xor history); default is bimodal.
module branch_predict #(
  parameter int PHT_AW = 6,
  parameter int GHR_W  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        branchF,
  output logic        pred_takeF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        branchD,
  input  logic        branch_takeD,
  output logic        pred_takeD,
  output logic        mispredictD
);

  localparam int PHT_N = 1 << PHT_AW;

  logic [1:0]        pht [PHT_N];
  logic [GHR_W-1:0]  ghr;
  logic [PHT_AW-1:0] idxF;
  logic [PHT_AW-1:0] idxD;
  logic              validD;
  logic              resolveD;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^{pcF[31:PHT_AW+2], pcF[1:0]};

`ifdef BPU_GSHARE_EN
  assign idxF = pcF[PHT_AW+1:2] ^ PHT_AW'(ghr);
`else
  assign idxF = pcF[PHT_AW+1:2];
`endif

  // Lookup reads the pre-update counter; there is deliberately no write bypass.
  assign pred_takeF = branchF & pht[idxF][1];

  // F->D carry: flush (or reset) clears, stall holds.
  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      validD     <= 1'b0;
      idxD       <= '0;
      pred_takeD <= 1'b0;
    end else if (!stallD) begin
      validD     <= branchF;
      idxD       <= idxF;
      pred_takeD <= pred_takeF;
    end
  end

  // Mispredict stays visible while stalled; only training is gated by stallD.
  assign resolveD    = validD & branchD & ~stallD;
  assign mispredictD = validD & branchD & (pred_takeD != branch_takeD);

  // A flush in the resolve cycle does not cancel training of the branch in Decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      ghr <= '0;
    end else if (resolveD) begin
      if (branch_takeD) begin
        if (pht[idxD] != 2'b11) pht[idxD] <= pht[idxD] + 2'd1;
      end else begin
        if (pht[idxD] != 2'b00) pht[idxD] <= pht[idxD] - 2'd1;
      end
      ghr <= {ghr[GHR_W-2:0], branch_takeD};
    end
  end

endmodule

// File: tb/tb_branch_predict.sv
// Directed bench for branch_predict: reset, training, saturation, stall, flush, history and mid-run reset.
module tb_branch_predict;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        branchF;
  logic        pred_takeF;
  logic        stallD;
  logic        flushD;
  logic        branchD;
  logic        branch_takeD;
  logic        pred_takeD;
  logic        mispredictD;

  int checks = 0;
  int errors = 0;
  logic [5:0] m_ghr = '0;

  branch_predict dut (
    .clk(clk), .rst(rst), .pcF(pcF), .branchF(branchF), .pred_takeF(pred_takeF),
    .stallD(stallD), .flushD(flushD), .branchD(branchD), .branch_takeD(branch_takeD),
    .pred_takeD(pred_takeD), .mispredictD(mispredictD)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PC whose fetch index lands on table entry idx under the current model history.
  function automatic logic [31:0] pc_for(input int idx);
    logic [5:0] i;
    i = idx[5:0];
`ifdef BPU_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return {24'h0, i, 2'b00};
  endfunction

  task automatic idle_inputs();
    branchF = 0; branchD = 0; branch_takeD = 0; stallD = 0; flushD = 0;
  endtask

  // Fetch a branch to entry idx, then resolve it in Decode with outcome taken.
  task automatic branch_pair(input string tag, input int idx, input logic taken,
                             input logic exp_pred, input logic exp_mis);
    idle_inputs();
    pcF = pc_for(idx); branchF = 1;
    #1 chk({tag, "_predF"}, 32'(pred_takeF), 32'(exp_pred));
    tick();
    branchF = 0; branchD = 1; branch_takeD = taken;
    #1 chk({tag, "_predD"}, 32'(pred_takeD), 32'(exp_pred));
    chk({tag, "_mis"}, 32'(mispredictD), 32'(exp_mis));
    tick();
    m_ghr = {m_ghr[4:0], taken};
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs(); pcF = 0; rst = 1;
    tick(); tick();
    rst = 0; m_ghr = '0;
  endtask

  initial begin
    do_reset();

    // Reset state
    pcF = 32'h10; branchF = 1; branchD = 1; branch_takeD = 1;
    #1 chk("rst_predF", 32'(pred_takeF), 0);
    chk("rst_predD", 32'(pred_takeD), 0);
    chk("rst_mis", 32'(mispredictD), 0);
    chk("rst_ghr", 32'(dut.ghr), 0);
    chk("rst_pht4", 32'(dut.pht[4]), 32'b01);
    tick();
    do_reset();

    // First branch: predict NT, resolve T -> mispredict, entry 01->10
    branch_pair("first", 4, 1, 0, 1);
    chk("first_pht4", 32'(dut.pht[4]), 32'b10);
    chk("first_ghr", 32'(dut.ghr), 32'b1);
    pcF = pc_for(4); branchF = 0;
    #1 chk("nobranch_predF", 32'(pred_takeF), 0);

    // Saturation: four taken resolves, then one not-taken
    branch_pair("sat1", 4, 1, 1, 0);
    branch_pair("sat2", 4, 1, 1, 0);
    branch_pair("sat3", 4, 1, 1, 0);
    branch_pair("sat4", 4, 1, 1, 0);
    chk("sat_pht4", 32'(dut.pht[4]), 32'b11);
    branch_pair("satnt", 4, 0, 1, 1);
    chk("satnt_pht4", 32'(dut.pht[4]), 32'b10);
    branch_pair("after_nt", 4, 1, 1, 0);

    // Stall: mispredicting branch held three cycles, one update on release
    pcF = pc_for(8); branchF = 1;
    tick();
    branchF = 0; branchD = 1; branch_takeD = 1; stallD = 1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("stall_mis", 32'(mispredictD), 1);
      chk("stall_pht8", 32'(dut.pht[8]), 32'b01);
      chk("stall_ghr", 32'(dut.ghr), 32'(m_ghr));
      tick();
    end
    stallD = 0;
    #1 chk("unstall_mis", 32'(mispredictD), 1);
    tick();
    m_ghr = {m_ghr[4:0], 1'b1};
    chk("unstall_pht8", 32'(dut.pht[8]), 32'b10);
    chk("unstall_ghr", 32'(dut.ghr), 32'(m_ghr));
    idle_inputs();

    // Flush on the fetch cycle: Decode slot is empty, nothing trains
    pcF = pc_for(12); branchF = 1; flushD = 1;
    tick();
    idle_inputs(); branchD = 1; branch_takeD = 1;
    #1 chk("flush_valid", 32'(dut.validD), 0);
    chk("flush_mis", 32'(mispredictD), 0);
    chk("flush_predD", 32'(pred_takeD), 0);
    tick();
    chk("flush_pht12", 32'(dut.pht[12]), 32'b01);
    chk("flush_ghr", 32'(dut.ghr), 32'(m_ghr));
    idle_inputs();

    // Flush in the resolve cycle still trains the Decode branch
    pcF = pc_for(16); branchF = 1;
    tick();
    branchF = 0; branchD = 1; branch_takeD = 1; flushD = 1;
    #1 chk("flushres_mis", 32'(mispredictD), 1);
    tick();
    m_ghr = {m_ghr[4:0], 1'b1};
    chk("flushres_pht16", 32'(dut.pht[16]), 32'b10);
    chk("flushres_ghr", 32'(dut.ghr), 32'(m_ghr));
    chk("flushres_valid", 32'(dut.validD), 0);
    idle_inputs();

    // History: T,N,T from reset
    do_reset();
    branch_pair("h1", 20, 1, 0, 1);
    branch_pair("h2", 24, 0, 0, 0);
    branch_pair("h3", 28, 1, 0, 1);
    chk("hist_ghr", 32'(dut.ghr), 32'b000101);
    pcF = 32'h10;
`ifdef BPU_GSHARE_EN
    #1 chk("hist_idx", 32'(dut.idxF), 1);
`else
    #1 chk("hist_idx", 32'(dut.idxF), 4);
`endif

    // Reset mid-run with a branch sitting in Decode
    branch_pair("mr1", 4, 1, 0, 1);
    branch_pair("mr2", 4, 1, 1, 0);
    chk("mr_pht4", 32'(dut.pht[4]), 32'b11);
    pcF = pc_for(4); branchF = 1;
    tick();
    branchF = 0; branchD = 1; branch_takeD = 0; rst = 1;
    tick();
    rst = 0; m_ghr = '0;
    branchD = 1; branch_takeD = 1; pcF = 32'h10; branchF = 1;
    #1 chk("mr_predF", 32'(pred_takeF), 0);
    chk("mr_ghr", 32'(dut.ghr), 0);
    chk("mr_mis", 32'(mispredictD), 0);
    chk("mr_pht4_after", 32'(dut.pht[4]), 32'b01);
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict.md
# branch_predict

Dynamic conditional-branch predictor for the 5-stage MIPS pipeline. Looks up a prediction in the Fetch stage for the branch being fetched. Carries that prediction into Decode and compares it with the resolved outcome from the Decode-stage comparator. Trains a 2-bit-counter pattern history table (PHT) and a global history register (GHR), and flags mispredictions so hazard/PC logic can redirect fetch.

## Interface
- `PHT_AW`, default 6: PHT index width; PHT has 2^PHT_AW 2-bit entries.
- `GHR_W`, default 6: global history width; must be ≤ PHT_AW.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pcF`  in  32  PC of the instruction in Fetch.
- `branchF`  in  1  predecode: Fetch instruction is a conditional branch (beq/bne/bgtz/blez/bltz/bgez/bltzal/bgezal).
- `pred_takeF`  out  1  prediction for Fetch instruction; 0 when branchF=0.
- `stallD`  in  1  Decode stage held this cycle.
- `flushD`  in  1  Decode stage squashed this cycle.
- `branchD`  in  1  decoder confirms Decode instruction is a conditional branch.
- `branch_takeD`  in  1  resolved outcome from the Decode comparator.
- `pred_takeD`  out  1  prediction carried into Decode.
- `mispredictD`  out  1  resolved outcome differs from prediction for a valid Decode branch.

## Operation
- Index: `idxF = pcF[PHT_AW+1:2] ^ {{(PHT_AW-GHR_W){1'b0}}, ghr}` (see Configuration).
- `pred_takeF = branchF & pht[idxF][1]`. Counter encoding: 00 strongly not taken, 01 weakly NT, 10 weakly T, 11 strongly T.
- F→D register holds `validD`, `idxD`, `pred_takeD`.
  - If rst or flushD, clear all three to 0.
  - Else if stallD, hold.
  - Else load `branchF`, `idxF`, `pred_takeF`.
- `resolveD = validD & branchD & ~stallD`.
- `mispredictD = validD & branchD & (pred_takeD != branch_takeD)`. This is combinational and is also asserted during stall cycles. Consumers qualify it with ~stallD.
- On resolveD:
  - `pht[idxD]` increments (saturate at 11) if branch_takeD=1, else decrements (saturate at 00).
  - `ghr <= {ghr[GHR_W-2:0], branch_takeD}`.
- No update when validD=0, branchD=0, or stallD=1. A flushD arriving the same cycle does not cancel the resolve of the instruction currently in Decode.
- Reset state: every PHT entry = 01, ghr = 0, validD = 0, pred_takeD = 0. Hence pred_takeF = 0 and mispredictD = 0 after reset.

## Timing
- Lookup has zero latency: pred_takeF is combinational from pcF and current state.
- pred_takeD and mispredictD are valid one cycle after the branch is in Fetch, assuming no stall.
- Training takes effect at the rising edge that ends the resolve cycle and is visible to lookups in the following cycle.
- Same-cycle read/write of the same PHT entry: the lookup sees the pre-update value, with no bypass.
- Back-to-back branches: the Fetch lookup uses the GHR before the Decode branch's outcome is shifted in.
- Reset mid-operation: state returns to reset values at that edge. A branch in Decode during the reset cycle is neither trained nor reported after reset.
- ghr wraps by discarding its MSB. PHT counters never wrap.

## Configuration
- `BPU_GSHARE_EN` defined: gshare indexing, i.e. the PC bits XOR the zero-extended ghr.
- `BPU_GSHARE_EN` undefined: bimodal indexing with `idxF = pcF[PHT_AW+1:2]`. ghr is still maintained so it can be observed in simulation, but it does not affect predictions.
- PHT update, mispredict, and pipeline behaviour are identical in both builds.

## Test plan
- Reset, then branchF=1 with any pcF: pred_takeF=0. Resolve taken: mispredictD=1 and the entry becomes 10. A next fetch at the same index gives pred_takeF=1.
- Saturation: resolve the same index taken 4 times → entry 11. Then resolve not-taken once → pred stays 1 (entry 10) and mispredictD=1 on that resolve.
- Stall: hold stallD=1 for 3 cycles with a valid mispredicting branch in Decode. mispredictD=1 throughout, and the PHT and ghr are unchanged until the first cycle with stallD=0, when exactly one update occurs.
- Flush: flushD=1 with branchF=1 → next cycle validD=0, and mispredictD=0 regardless of branchD/branch_takeD. No training occurs.
- GHR (gshare build): resolve outcomes T,N,T from reset → ghr=6'b000101. pcF=0x00000010 indexes entry 4^5=1. Bimodal build with the same stimulus indexes entry 4.
- Reset mid-run: after training entry 4 to 11, assert rst for one cycle → pred_takeF=0 at pcF=0x10, ghr=0, mispredictD=0.
